// File: rtl/ram_io_reader.sv
// Reader side of the data-RAM word interface: sweeps a clamped range of words
// under a req/gnt arbitration and streams each captured word over valid/ready.
module ram_io_reader #(
    parameter int unsigned DEPTH_WORDS = 102,
    parameter int unsigned IDX_W       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] base_word,
    input  logic [IDX_W-1:0] count,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      ram_a,
    output logic             ram_we,
    input  logic [31:0]      ram_rd,
    output logic [31:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_READ = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] remaining;

    logic [IDX_W:0]   depth_ext;
    logic [IDX_W:0]   range_end;
    logic             overrun;
    logic [IDX_W-1:0] clamp_rem;
    logic [IDX_W-1:0] start_rem;

    // Range end is formed one bit wider so base+count cannot wrap.
    assign depth_ext = (IDX_W+1)'(DEPTH_WORDS);
    assign range_end = {1'b0, base_word} + {1'b0, count};
    assign overrun   = (range_end > depth_ext);

    always_comb begin
        clamp_rem = '0;
        if ({1'b0, base_word} < depth_ext) begin
            clamp_rem = IDX_W'(DEPTH_WORDS) - base_word;
        end
        start_rem = overrun ? clamp_rem : count;
    end

    // Bus-facing outputs decode from state only so reset clears them at once.
    assign bus_req = (state == S_REQ) || (state == S_READ);
    assign ram_a   = (state == S_READ) ? {{(30-IDX_W){1'b0}}, word_idx, 2'b00} : '0;
    assign ram_we  = 1'b0;
    assign valid_o = (state == S_SEND);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            remaining <= '0;
            data_o    <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        word_idx  <= base_word;
                        remaining <= start_rem;
                        err       <= overrun;
                        state     <= (start_rem == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) state <= S_READ;
                end
                S_READ: begin
                    if (bus_gnt) begin
                        data_o <= ram_rd;
                        state  <= S_SEND;
                    end else begin
                        state  <= S_REQ;
                    end
                end
                S_SEND: begin
                    if (ready_i) begin
                        word_idx  <= word_idx + 1'b1;
                        remaining <= remaining - 1'b1;
                        state     <= (remaining == IDX_W'(1)) ? S_DONE : S_REQ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_io_reader.sv
// Directed bench for ram_io_reader: table of clean transfers plus hand-built
// sequences for grant stalls, consumer back-pressure and asynchronous reset.
module tb_ram_io_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_word = '0;
    logic [11:0] count = '0;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [31:0] ram_a;
    logic        ram_we;
    logic [31:0] ram_rd;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    ram_io_reader #(.DEPTH_WORDS(102), .IDX_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_word(base_word), .count(count),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .ram_a(ram_a), .ram_we(ram_we),
        .ram_rd(ram_rd), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input int unsigned i);
        logic [31:0] w;
        if (i < 4) w = 32'h1111_1111 * (i + 1);
        else       w = {16'hC0DE, 16'(i)};
        return w;
    endfunction

    logic [31:0] mem [0:101];
    logic [11:0] ram_idx;
    assign ram_idx = ram_a[13:2];
    assign ram_rd  = (ram_idx < 12'd102) ? mem[ram_idx] : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] base;
        logic [11:0] cnt;
        int          n;
        logic        err;
        int          done_c;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int c, n, done_c, first_c, k;
        logic req_seen, we_seen;
        logic [31:0] prev_a;

        for (int unsigned i = 0; i < 102; i++) mem[i] = exp_word(i);

        vecs[0] = '{base: 12'd0,   cnt: 12'd4, n: 4, err: 1'b0, done_c: 13};
        vecs[1] = '{base: 12'd100, cnt: 12'd5, n: 2, err: 1'b1, done_c: 7};
        vecs[2] = '{base: 12'd0,   cnt: 12'd0, n: 0, err: 1'b0, done_c: 1};
        vecs[3] = '{base: 12'd50,  cnt: 12'd3, n: 3, err: 1'b0, done_c: 10};
        vecs[4] = '{base: 12'd101, cnt: 12'd1, n: 1, err: 1'b0, done_c: 4};
        vecs[5] = '{base: 12'd102, cnt: 12'd1, n: 0, err: 1'b1, done_c: 1};
        vecs[6] = '{base: 12'd98,  cnt: 12'd4, n: 4, err: 1'b0, done_c: 13};
        vecs[7] = '{base: 12'd200, cnt: 12'd3, n: 0, err: 1'b1, done_c: 1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_addr", ram_a, 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        rst_n = 1'b1;

        // Clean transfers with grant and ready held high
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            base_word = vecs[v].base; count = vecs[v].cnt; start = 1'b1;
            @(negedge clk);
            start = 1'b0; base_word = '0; count = '0;
            c = 1; n = 0; done_c = -1; first_c = -1;
            req_seen = 1'b0; we_seen = 1'b0; prev_a = '0;
            while (c <= 60 && done_c < 0) begin
                if (bus_req) req_seen = 1'b1;
                if (ram_we)  we_seen = 1'b1;
                if (valid_o) begin
                    if (first_c < 0) first_c = c;
                    check("vec_read_addr", prev_a, 32'(vecs[v].base + 12'(n)) << 2);
                    check("vec_word", data_o, exp_word(int'(vecs[v].base) + n));
                    n++;
                end
                if (done) begin
                    done_c = c;
                    check("vec_err_at_done", 32'(err), 32'(vecs[v].err));
                end
                prev_a = ram_a;
                @(negedge clk);
                c++;
            end
            check("vec_done_cycle", 32'(done_c), 32'(vecs[v].done_c));
            check("vec_word_count", 32'(n), 32'(vecs[v].n));
            check("vec_first_valid", 32'(first_c), (vecs[v].n > 0) ? 32'd3 : 32'hFFFF_FFFF);
            check("vec_req_seen", 32'(req_seen), 32'(vecs[v].n > 0));
            check("vec_we_seen", 32'(we_seen), 32'd0);
            check("vec_idle_busy", 32'(busy), 32'd0);
            check("vec_err_sticky", 32'(err), 32'(vecs[v].err));
        end

        // Grant withheld in REQ, then dropped once during READ
        @(negedge clk);
        bus_gnt = 1'b0; base_word = 12'd10; count = 12'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_req", 32'(bus_req), 32'd1);
            check("stall_addr", ram_a, 32'd0);
            check("stall_valid", 32'(valid_o), 32'd0);
            if (i == 2) bus_gnt = 1'b1;
            @(negedge clk);
        end
        check("stall_read_addr", ram_a, 32'h28);
        bus_gnt = 1'b0;
        @(negedge clk);
        check("drop_addr", ram_a, 32'd0);
        check("drop_req", 32'(bus_req), 32'd1);
        check("drop_valid", 32'(valid_o), 32'd0);
        bus_gnt = 1'b1;
        @(negedge clk);
        check("regrant_addr", ram_a, 32'h28);
        @(negedge clk);
        check("stall_valid0", 32'(valid_o), 32'd1);
        check("stall_word0", data_o, exp_word(10));
        repeat (2) @(negedge clk);
        check("stall_addr1", ram_a, 32'h2C);
        @(negedge clk);
        check("stall_word1", data_o, exp_word(11));
        @(negedge clk);
        check("stall_done", 32'(done), 32'd1);

        // Consumer back-pressure with an ignored start during the transfer
        @(negedge clk);
        ready_i = 1'b0; base_word = 12'd20; count = 12'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!valid_o && k < 10) begin @(negedge clk); k++; end
        check("bp_valid_timeout", 32'(k < 10), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(valid_o), 32'd1);
            check("bp_data_held", data_o, exp_word(20));
            if (i == 1) begin start = 1'b1; base_word = 12'd60; count = 12'd1; end
            if (i == 2) begin start = 1'b0; base_word = '0; count = '0; end
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        k = 0;
        while (!valid_o && k < 10) begin @(negedge clk); k++; end
        check("bp_second_word", data_o, exp_word(21));
        @(negedge clk);
        check("bp_done", 32'(done), 32'd1);
        @(negedge clk);
        check("bp_no_relatch", 32'(busy), 32'd0);

        // Asynchronous reset while waiting in SEND
        ready_i = 1'b0; base_word = 12'd30; count = 12'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!valid_o && k < 10) begin @(negedge clk); k++; end
        check("ar_valid_before", 32'(valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(valid_o), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_req", 32'(bus_req), 32'd0);
        check("ar_data", data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ready_i = 1'b1;
        base_word = 12'd2; count = 12'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!valid_o && k < 10) begin @(negedge clk); k++; end
        check("ar_fresh_word", data_o, 32'h3333_3333);
        @(negedge clk);
        check("ar_fresh_done", 32'(done), 32'd1);
        check("ar_fresh_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_io_reader.md
Name: ram_io_reader

Overview:
- Reader side of the data-RAM word interface.
- On a start pulse, sweeps a contiguous range of RAM words by driving the RAM address bus with write-enable held low.
- Captures the combinational read data and streams each word out over a valid/ready handshake, e.g. to the I/O output path.
- Shares the RAM port with the processor through a req/gnt pair and drives the address bus only while granted.

Parameters:
- DEPTH_WORDS, 102, number of implemented RAM words; word indices at or above this are out of range.
- IDX_W, 12, width of word index and count fields, matching the RAM's word-address field (address bits 13:2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_word  input  IDX_W  first word index; sampled with start.
- count  input  IDX_W  number of words to read; sampled with start.
- bus_req  output  1  request for the RAM port.
- bus_gnt  input  1  RAM port granted this cycle.
- ram_a  output  32  byte address to RAM; equals {zeros, word_idx, 2'b00} in READ, 0 otherwise.
- ram_we  output  1  constant 0.
- ram_rd  input  32  RAM read data, combinational from ram_a.
- data_o  output  32  captured word.
- valid_o  output  1  data_o valid.
- ready_i  input  1  consumer accepts data_o.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a transfer.
- err  output  1  sticky truncation flag; cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=IDLE; word_idx, remaining, data_o and err are all 0.
  - bus_req, valid_o, done, busy and ram_a are all 0; ram_we is 0 always.
- Index clamping: on an accepted start, if base_word+count > DEPTH_WORDS (compute in IDX_W+1 bits), then remaining = max(DEPTH_WORDS-base_word, 0) and err=1; otherwise remaining=count and err=0.
- IDLE:
  - start=1: latch word_idx=base_word and remaining as above.
  - Next state is DONE if remaining==0, else REQ.
- REQ: bus_req=1; bus_gnt=1 -> READ; otherwise stay.
- READ:
  - bus_req=1; ram_a={word_idx,2'b00}.
  - bus_gnt=1: data_o<=ram_rd at the clock edge, next SEND.
  - bus_gnt=0: next REQ, no capture, no index change.
- SEND:
  - bus_req=0, ram_a=0, valid_o=1; data_o is held stable until handshake.
  - ready_i=1: word_idx++ and remaining-- (wrap impossible because of clamping).
  - After the handshake, next state is DONE if remaining was 1, else REQ.
  - ready_i=0: stay in SEND.
- DONE: done=1 for exactly one cycle, then IDLE; err keeps its value.
- Throughput: with bus_gnt=1 and ready_i=1 held, one word per 3 cycles.
  - First valid_o rises 3 cycles after the edge that samples start (REQ, READ, SEND).
  - done is high in the cycle after the last handshake.
- start while busy: ignored; no relatch.
- start in IDLE with count=0: DONE the next cycle; no bus_req, no valid_o.
- Reset mid-transfer: everything returns to reset values immediately; a pending valid_o is dropped.
- valid_o, once asserted, is never deasserted without a handshake, except by reset.
- ram_we is never 1 in any state.

Test Plan:
- RAM words 0..3 preloaded with 0x11111111 to 0x44444444; base_word=0, count=4; bus_gnt=1, ready_i=1 -> data_o sequence 0x11111111 to 0x44444444.
  - ram_a seen in READ: 0x0, 0x4, 0x8, 0xC.
  - First valid_o 3 cycles after start; done pulse in cycle 13; err=0.
- base_word=100, count=5 (DEPTH_WORDS=102) -> exactly 2 words read (indices 100 and 101, ram_a 0x190 and 0x194); err=1 with done; err cleared by the next valid start.
- count=0 -> done high 1 cycle after start; bus_req and valid_o never high; busy high for 1 cycle.
- bus_gnt low for 3 cycles in REQ, then dropped during READ once -> no capture while ungranted, ram_a=0 outside READ, data_o correct, word order unchanged.
- ready_i held low 5 cycles in SEND -> valid_o and data_o stable throughout; second start pulse during the transfer ignored (base_word unchanged).
- rst_n asserted low mid-SEND, asynchronously between edges -> valid_o, busy and bus_req drop to 0 without a clock edge; after release, a fresh start with base_word=2, count=1 returns RAM word 2.
